// File: rtl/q_learning_pkg.sv
// Shared types and width helpers for the Q-learning update engine.
package q_learning_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } q_state_e;

  // Index width for a table dimension of n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Internal Bellman arithmetic width: three guard bits above the data width.
  function automatic int unsigned calc_width(input int unsigned data_width);
    return data_width + 3;
  endfunction

endpackage

// File: rtl/q_update_engine_if.sv
// Transition handshake and result bus of the Q-learning update engine.
interface q_update_engine_if #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned STATES_WIDTH  = 4,
  parameter int unsigned ACTIONS_WIDTH = 2
);
  logic                            i_valid;
  logic                            o_ready;
  logic [STATES_WIDTH-1:0]         i_st;
  logic [ACTIONS_WIDTH-1:0]        i_at;
  logic [STATES_WIDTH-1:0]         i_next_st;
  logic signed [DATA_WIDTH-1:0]    i_rt;
  logic                            i_terminal;
  logic                            o_valid;
  logic [ACTIONS_WIDTH-1:0]        o_at_max;
  logic signed [DATA_WIDTH-1:0]    o_q_new;

  modport master (
    output i_valid, i_st, i_at, i_next_st, i_rt, i_terminal,
    input  o_ready, o_valid, o_at_max, o_q_new
  );

  modport slave (
    input  i_valid, i_st, i_at, i_next_st, i_rt, i_terminal,
    output o_ready, o_valid, o_at_max, o_q_new
  );
endinterface

// File: rtl/q_max_scan.sv
// Running max/argmax accumulator; strict-greater compare keeps the lowest index on ties.
module q_max_scan #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned INDEX_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [DATA_WIDTH-1:0]  value,
  input  logic [INDEX_WIDTH-1:0]        index,
  output logic signed [DATA_WIDTH-1:0]  max_val,
  output logic [INDEX_WIDTH-1:0]        max_idx
);

  logic seen;

  // First enabled sample is always taken, later ones only if strictly larger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen    <= 1'b0;
      max_val <= '0;
      max_idx <= '0;
    end else if (clr) begin
      seen    <= 1'b0;
      max_val <= '0;
      max_idx <= '0;
    end else if (en && (!seen || (value > max_val))) begin
      seen    <= 1'b1;
      max_val <= value;
      max_idx <= index;
    end
  end

endmodule

// File: rtl/q_update_engine.sv
// Q-table holder with sequential max scan and shift-based Bellman update.
// Build option: define Q_SATURATE_EN to clamp q_new instead of wrapping it.
module q_update_engine
  import q_learning_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_STATES  = 16,
  parameter int unsigned NUM_ACTIONS = 4,
  parameter int unsigned ALPHA_SHIFT = 1,
  parameter int unsigned GAMMA_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  q_update_engine_if.slave bus
);

  localparam int unsigned STATES_WIDTH  = idx_width(NUM_STATES);
  localparam int unsigned ACTIONS_WIDTH = idx_width(NUM_ACTIONS);
  localparam int unsigned CALC_WIDTH    = calc_width(DATA_WIDTH);
  localparam int unsigned LAST_ACTION   = NUM_ACTIONS - 1;

  q_state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] q_table [NUM_STATES][NUM_ACTIONS];

  logic [STATES_WIDTH-1:0]      st_r, next_st_r;
  logic [ACTIONS_WIDTH-1:0]     at_r, scan_idx_q;
  logic signed [DATA_WIDTH-1:0] rt_r, q_new_r;
  logic                         term_r;

  logic accept_c, scan_en_c, write_en_c;

  logic signed [DATA_WIDTH-1:0] max_val;
  logic [ACTIONS_WIDTH-1:0]     max_idx;

  logic signed [CALC_WIDTH-1:0] q_old_c, maxq_c, target_c, delta_c, q_sum_c;
  logic signed [DATA_WIDTH-1:0] q_new_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    scan_en_c  = 1'b0;
    write_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          accept_c = 1'b1;
          state_d  = bus.i_terminal ? UPDATE : SCAN;
        end
      end
      SCAN: begin
        scan_en_c = 1'b1;
        if (scan_idx_q == ACTIONS_WIDTH'(LAST_ACTION)) state_d = UPDATE;
      end
      UPDATE: begin
        write_en_c = 1'b1;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transition capture and scan index; inputs are free to change after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r       <= '0;
      at_r       <= '0;
      next_st_r  <= '0;
      rt_r       <= '0;
      term_r     <= 1'b0;
      scan_idx_q <= '0;
    end else if (accept_c) begin
      st_r       <= bus.i_st;
      at_r       <= bus.i_at;
      next_st_r  <= bus.i_next_st;
      rt_r       <= bus.i_rt;
      term_r     <= bus.i_terminal;
      scan_idx_q <= '0;
    end else if (scan_en_c) begin
      scan_idx_q <= scan_idx_q + ACTIONS_WIDTH'(1);
    end
  end

  q_max_scan #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (ACTIONS_WIDTH)
  ) u_max_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept_c),
    .en      (scan_en_c),
    .value   (q_table[next_st_r][scan_idx_q]),
    .index   (scan_idx_q),
    .max_val (max_val),
    .max_idx (max_idx)
  );

  // Bellman update in widened signed arithmetic.
  assign q_old_c  = CALC_WIDTH'(q_table[st_r][at_r]);
  assign maxq_c   = term_r ? '0 : CALC_WIDTH'(max_val);
  assign target_c = CALC_WIDTH'(rt_r) + maxq_c - (maxq_c >>> GAMMA_SHIFT);
  assign delta_c  = (target_c - q_old_c) >>> ALPHA_SHIFT;
  assign q_sum_c  = q_old_c + delta_c;

`ifdef Q_SATURATE_EN
  localparam logic signed [CALC_WIDTH-1:0] Q_MAX = {4'b0000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [CALC_WIDTH-1:0] Q_MIN = {4'b1111, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    q_new_c = q_sum_c[DATA_WIDTH-1:0];
    if (q_sum_c > Q_MAX)      q_new_c = Q_MAX[DATA_WIDTH-1:0];
    else if (q_sum_c < Q_MIN) q_new_c = Q_MIN[DATA_WIDTH-1:0];
  end
`else
  always_comb begin
    q_new_c = q_sum_c[DATA_WIDTH-1:0];
  end
`endif

  // Table write happens only in UPDATE, so reset mid-transaction leaves no partial write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        for (int a = 0; a < NUM_ACTIONS; a++) begin
          q_table[s][a] <= '0;
        end
      end
      q_new_r <= '0;
    end else if (write_en_c) begin
      q_table[st_r][at_r] <= q_new_c;
      q_new_r             <= q_new_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.o_ready  <= 1'b1;
      bus.o_valid  <= 1'b0;
      bus.o_at_max <= '0;
      bus.o_q_new  <= '0;
    end else begin
      bus.o_ready <= (state_d == IDLE);
      bus.o_valid <= (state_q == DONE);
      if (state_q == DONE) begin
        bus.o_at_max <= term_r ? '0 : max_idx;
        bus.o_q_new  <= q_new_r;
      end
    end
  end

endmodule

// File: tb/tb_q_update_engine.sv
// Self-checking bench: directed vector table, handshake/reset sequences, random vs reference model.
module tb_q_update_engine;

  localparam int unsigned DW = 16;
  localparam int unsigned NS = 4;
  localparam int unsigned NA = 4;
  localparam int unsigned SW = 2;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  q_update_engine_if #(.DATA_WIDTH(DW), .STATES_WIDTH(SW), .ACTIONS_WIDTH(AW)) bus ();

  q_update_engine #(
    .DATA_WIDTH  (DW),
    .NUM_STATES  (NS),
    .NUM_ACTIONS (NA),
    .ALPHA_SHIFT (1),
    .GAMMA_SHIFT (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int s;
    int a;
    int ns;
    int r;
    bit term;
    int exp_q;
    int exp_at;
    int exp_lat;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int model_q [NS][NA];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int reduce(input int v);
`ifdef Q_SATURATE_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    int w;
    w = v & 32'h0000_FFFF;
    if (w >= 32768) w = w - 65536;
    return w;
`endif
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < NA; a++)
        model_q[s][a] = 0;
  endfunction

  // alpha = 1/2, gamma = 3/4; shifts on int are floor divisions by powers of two.
  task automatic model_step(input int s, input int a, input int ns, input int r, input bit term,
                            output int qn, output int best);
    int mx;
    int target;
    best = 0;
    mx   = model_q[ns][0];
    for (int k = 1; k < NA; k++) begin
      if (model_q[ns][k] > mx) begin
        mx   = model_q[ns][k];
        best = k;
      end
    end
    if (term) begin
      mx   = 0;
      best = 0;
    end
    target = r + mx - (mx >>> 2);
    qn = reduce(model_q[s][a] + ((target - model_q[s][a]) >>> 1));
    model_q[s][a] = qn;
  endtask

  // Called and returns at a negedge. lat = cycles from accept edge to o_valid, -1 on timeout.
  task automatic run_txn(input int s, input int a, input int ns, input int r, input bit term,
                         output int q, output int at, output int lat, output bit ready_ok);
    int wc;
    wc       = 0;
    q        = 0;
    at       = 0;
    lat      = -1;
    ready_ok = 1'b1;
    while (!bus.o_ready && wc < 50) begin
      @(negedge clk);
      wc++;
    end
    bus.i_valid    = 1'b1;
    bus.i_st       = SW'(s);
    bus.i_at       = AW'(a);
    bus.i_next_st  = SW'(ns);
    bus.i_rt       = DW'(r);
    bus.i_terminal = term;
    @(posedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.i_valid    = 1'b0;
        bus.i_st       = SW'($urandom);
        bus.i_at       = AW'($urandom);
        bus.i_next_st  = SW'($urandom);
        bus.i_rt       = DW'($urandom);
        bus.i_terminal = 1'($urandom);
      end
      if (bus.o_valid) begin
        lat = k;
        q   = int'(bus.o_q_new);
        at  = int'(bus.o_at_max);
        break;
      end
      if (bus.o_ready) ready_ok = 1'b0;
    end
  endtask

  initial begin
    vec_t vecs[7];
    int q, at, lat, mq, mat;
    bit rok;
    int accepts, pulses;
    int acc_at[4];

    bus.i_valid    = 1'b0;
    bus.i_st       = '0;
    bus.i_at       = '0;
    bus.i_next_st  = '0;
    bus.i_rt       = '0;
    bus.i_terminal = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_ready",  int'(bus.o_ready), 1);
    check("reset_valid",  int'(bus.o_valid), 0);
    check("reset_at_max", int'(bus.o_at_max), 0);
    check("reset_q_new",  int'(bus.o_q_new), 0);

    vecs[0] = '{s:2, a:0, ns:1, r:0,     term:0, exp_q:0,     exp_at:0, exp_lat:6};
    vecs[1] = '{s:0, a:1, ns:2, r:100,   term:0, exp_q:50,    exp_at:0, exp_lat:6};
    vecs[2] = '{s:2, a:3, ns:0, r:0,     term:0, exp_q:19,    exp_at:1, exp_lat:6};
    vecs[3] = '{s:1, a:0, ns:0, r:-64,   term:1, exp_q:-32,   exp_at:0, exp_lat:2};
    vecs[4] = '{s:3, a:0, ns:3, r:32767, term:0, exp_q:16383, exp_at:0, exp_lat:6};
    vecs[5] = '{s:3, a:0, ns:3, r:32767, term:0, exp_q:30719, exp_at:0, exp_lat:6};
`ifdef Q_SATURATE_EN
    vecs[6] = '{s:3, a:0, ns:3, r:32767, term:0, exp_q:32767, exp_at:0, exp_lat:6};
`else
    vecs[6] = '{s:3, a:0, ns:3, r:32767, term:0, exp_q:-22273, exp_at:0, exp_lat:6};
`endif

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].s, vecs[i].a, vecs[i].ns, vecs[i].r, vecs[i].term, q, at, lat, rok);
      model_step(vecs[i].s, vecs[i].a, vecs[i].ns, vecs[i].r, vecs[i].term, mq, mat);
      check($sformatf("vec%0d_q_new", i),   q,        vecs[i].exp_q);
      check($sformatf("vec%0d_at_max", i),  at,       vecs[i].exp_at);
      check($sformatf("vec%0d_latency", i), lat,      vecs[i].exp_lat);
      check($sformatf("vec%0d_busy", i),    int'(rok), 1);
    end

    // i_valid held through busy periods: one accept per 7 cycles.
    accepts = 0;
    pulses  = 0;
    bus.i_valid    = 1'b1;
    bus.i_st       = SW'(1);
    bus.i_at       = AW'(2);
    bus.i_next_st  = SW'(0);
    bus.i_rt       = DW'(10);
    bus.i_terminal = 1'b0;
    for (int n = 0; n < 21; n++) begin
      if (n > 0 && bus.o_valid) pulses++;
      if (bus.o_ready) begin
        if (accepts < 4) acc_at[accepts] = n;
        accepts++;
      end
      @(negedge clk);
    end
    if (bus.o_valid) pulses++;
    bus.i_valid = 1'b0;
    for (int i = 0; i < 3; i++) model_step(1, 2, 0, 10, 1'b0, mq, mat);
    check("hold_accepts", accepts, 3);
    check("hold_pulses",  pulses, 3);
    if (accepts >= 3) begin
      check("hold_gap0", acc_at[1] - acc_at[0], 7);
      check("hold_gap1", acc_at[2] - acc_at[1], 7);
    end
    check("hold_q_new", int'(bus.o_q_new), mq);

    // Reset pulsed mid-SCAN aborts the update and clears the table.
    bus.i_valid    = 1'b1;
    bus.i_st       = SW'(0);
    bus.i_at       = AW'(1);
    bus.i_next_st  = SW'(2);
    bus.i_rt       = DW'(500);
    bus.i_terminal = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready",  int'(bus.o_ready), 1);
    check("midrst_valid",  int'(bus.o_valid), 0);
    check("midrst_at_max", int'(bus.o_at_max), 0);
    check("midrst_q_new",  int'(bus.o_q_new), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
    run_txn(0, 1, 0, 0, 1'b0, q, at, lat, rok);
    model_step(0, 1, 0, 0, 1'b0, mq, mat);
    check("postrst_q01",  q,   0);
    check("postrst_at",   at,  0);
    check("postrst_lat",  lat, 6);

    // Randomised transitions against the reference model.
    for (int i = 0; i < 40; i++) begin
      int s, a, ns, r;
      bit term;
      s    = int'($urandom_range(0, NS - 1));
      a    = int'($urandom_range(0, NA - 1));
      ns   = int'($urandom_range(0, NS - 1));
      r    = int'($urandom_range(0, 65535)) - 32768;
      if (i % 3 == 0) r = r >>> 6;
      term = ($urandom_range(0, 3) == 0);
      run_txn(s, a, ns, r, term, q, at, lat, rok);
      model_step(s, a, ns, r, term, mq, mat);
      check($sformatf("rnd%0d_q_new", i),   q,   mq);
      check($sformatf("rnd%0d_at_max", i),  at,  mat);
      check($sformatf("rnd%0d_latency", i), lat, term ? 2 : 6);
      check($sformatf("rnd%0d_busy", i),    int'(rok), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
